lsu_byte_sequencer: RTL and testbench
=====================================

# lsu_byte_sequencer

Load/store sequencer between the core's memory stage and the byte-wide data RAM. Accepts one byte, halfword or word load/store per request, checks alignment, then performs it as a series of single-byte RAM accesses, one per cycle, in little-endian order. Load data is sign- or zero-extended. A misaligned request, or a RAM address exception on any byte, is returned as a fault.

## Interface
- `ram_width`, default 12: RAM address width, passed through to the RAM instance. Used only for documentation and assertions; the range check itself is done by the RAM.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle and able to accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_len` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_unsigned` in 1: load zero-extends when 1 and sign-extends when 0; ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; byte k is `req_wdata[8k+7:8k]`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data, valid with `resp_valid`; 0 for stores and faults.
- `resp_fault` out 1: valid with `resp_valid`; set on misalignment, illegal length or RAM exception.
- `ram_rw` out 1: RAM write strobe.
- `ram_len` out 2: tied to 00, because every RAM access is a single byte.
- `ram_addr` out 32: RAM byte address.
- `ram_write` out 32: `ram_write[7:0]` holds the byte being stored; upper bits are 0.
- `ram_read` in 32: RAM read data; only `[7:0]` is used.
- `ram_exception` in 1: RAM out-of-range flag, evaluated combinationally against `ram_addr`.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr, we, len, unsigned and wdata; set N to 1, 2 or 4; clear byte counter k and the data shift register.
  - Illegal length (11), halfword with `addr[0]`=1, or word with `addr[1:0]`≠0: go to RESP with the fault flag set. No RAM access occurs.
  - Otherwise go to ACCESS.
- **ACCESS**
  - `ram_addr` = base+k; `ram_rw` = we; `ram_write[7:0]` = wdata byte k.
  - On a load, capture `ram_read[7:0]` into result byte k at the end of the cycle.
  - If `ram_exception`=1: set the fault flag and go to RESP. Remaining bytes are skipped. Store bytes already written stay written.
  - Else if k = N-1: go to RESP.
  - Else k increments.
- **RESP**
  - `resp_valid`=1 for one cycle, then IDLE.
  - Load data: byte result in `[7:0]`, halfword in `[15:0]`, word in `[31:0]`; upper bits filled with the top bit of the result when `req_unsigned`=0, with zeros when 1.
- **Outside ACCESS:** `ram_rw`=0, `ram_addr`=0, `ram_write`=0.
  - The RAM write is level-sensitive, so `ram_rw` must never be high with a stale address.
- **Address arithmetic:** base+k is 32-bit and wraps modulo 2^32. Aligned requests cannot carry across a word boundary.
- All outputs are decoded from registered state only. There is no combinational path from the `req_*` inputs to any output.

## Timing
- A request is accepted in cycle T when `req_valid`=1 and `req_ready`=1 (IDLE only).
- Byte k is accessed in cycle T+1+k; `resp_valid` is in cycle T+1+N.
  - Latency: byte 2, halfword 3, word 5 cycles.
- Alignment fault: `resp_valid` in cycle T+1.
- RAM exception on byte k: `resp_valid` in cycle T+2+k.
- `req_ready`=0 from T+1 through the RESP cycle; the next request can be accepted in the cycle after RESP.
- `req_valid` while busy is ignored; the requester holds it until accepted.
- **Reset values:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `ram_rw`=0, `ram_addr`=0, `ram_write`=0.
- **Reset mid-operation:**
  - The operation is abandoned and no response is issued.
  - `ram_rw` is 0 from the reset cycle's edge onward.
  - Store bytes already written remain written.

## Test plan
- Word store 0xA1B2C3D4 to 0x100, then word load from 0x100 → four `ram_rw` pulses at 0x100..0x103 with bytes D4, C3, B2, A1; load returns 0xA1B2C3D4, fault 0, latency 5 each.
- Byte load of 0x80 from 0x104: signed → 0xFFFFFF80; unsigned → 0x00000080; halfword 0x8001 from 0x106, signed → 0xFFFF8001.
- Halfword load at 0x101, word at 0x102, `req_len`=11 → fault=1 and rdata=0 at T+1; `ram_rw` and `ram_addr` stay 0 throughout.
- Word access at base 2^(`ram_width`+1): the RAM raises `ram_exception` on byte 0 → fault at T+2, only one access cycle. With `ram_width`=12, word store at 0x1FFC does not fault, and 0x2000 faults.
- Back-to-back byte requests with `req_valid` held high → accepted every 3 cycles; requests presented while busy do not disturb the RAM address.
- Assert `rst` at T+2 of a word store → only bytes 0–1 written, no `resp_valid`, all outputs at reset values after the edge.

Source files
------------

// File: rtl/lsu_byte_sequencer_if.sv
// Request/response bus between the memory stage and the byte sequencer.
// The memory stage is the master; the sequencer is the slave.
interface lsu_byte_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_len;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid,
    output req_we,
    output req_len,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_fault
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_len,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_fault
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits byte/half/word loads and stores into single-byte RAM accesses,
// little-endian, one per cycle, with alignment and RAM range faults.
module lsu_byte_sequencer #(
  parameter int ram_width = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  lsu_byte_sequencer_if.slave         bus,
  output logic                        ram_rw,
  output logic [1:0]                  ram_len,
  output logic [31:0]                 ram_addr,
  output logic [31:0]                 ram_write,
  input  logic [31:0]                 ram_read,
  input  logic                        ram_exception
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] data;
  logic        we;
  logic        uns;
  logic        fault;
  logic [1:0]  len;
  logic [1:0]  k;
  logic [1:0]  last;
  logic        bad;
  logic [1:0]  last_in;
  logic        last_hit;
  logic        unused_bits;

  assign unused_bits = ^ram_read[31:8];

  always_comb begin
    bad     = 1'b0;
    last_in = 2'd0;
    unique case (1'b1)
      bus.req_len == 2'b00: last_in = 2'd0;
      bus.req_len == 2'b01: begin
        last_in = 2'd1;
        bad     = bus.req_addr[0];
      end
      bus.req_len == 2'b10: begin
        last_in = 2'd3;
        bad     = |bus.req_addr[1:0];
      end
      bus.req_len == 2'b11: bad = 1'b1;
      default: bad = 1'b1;
    endcase
  end

  assign last_hit = (k == last);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (bus.req_valid)
          state_n = bad ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (ram_exception || last_hit)
          state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base  <= '0;
      wdata <= '0;
      data  <= '0;
      we    <= 1'b0;
      uns   <= 1'b0;
      fault <= 1'b0;
      len   <= '0;
      k     <= '0;
      last  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            base  <= bus.req_addr;
            wdata <= bus.req_wdata;
            we    <= bus.req_we;
            uns   <= bus.req_unsigned;
            len   <= bus.req_len;
            last  <= last_in;
            fault <= bad;
            k     <= '0;
            data  <= '0;
          end
        end
        S_ACCESS: begin
          if (!we)
            data[{k, 3'b000} +: 8] <= ram_read[7:0];
          if (ram_exception)
            fault <= 1'b1;
          else if (!last_hit)
            k <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // RAM strobes are gated by state so no stale address is ever written.
  always_comb begin
    ram_len   = 2'b00;
    ram_rw    = 1'b0;
    ram_addr  = '0;
    ram_write = '0;
    if (state == S_ACCESS) begin
      ram_rw    = we;
      ram_addr  = base + {30'd0, k};
      ram_write = {24'd0, wdata[{k, 3'b000} +: 8]};
    end
  end

  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    bus.resp_fault = (state == S_RESP) && fault;
    bus.resp_rdata = '0;
    if (state == S_RESP && !we && !fault) begin
      unique case (len)
        2'b00:
          bus.resp_rdata = {{24{~uns & data[7]}}, data[7:0]};
        2'b01:
          bus.resp_rdata = {{16{~uns & data[15]}}, data[15:0]};
        default:
          bus.resp_rdata = data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && !ram_exception)
      assert ((ram_addr >> (ram_width + 1)) == 32'd0);
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Scoreboard bench: byte RAM model with range fault, expected responses
// and RAM writes queued at issue time and compared as the DUT produces them.
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_rw;
  logic [1:0]  ram_len;
  logic [31:0] ram_addr;
  logic [31:0] ram_write;
  logic [31:0] ram_read;
  logic        ram_exception;

  lsu_byte_sequencer_if ifc ();

  lsu_byte_sequencer #(.ram_width(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (ifc),
    .ram_rw        (ram_rw),
    .ram_len       (ram_len),
    .ram_addr      (ram_addr),
    .ram_write     (ram_write),
    .ram_read      (ram_read),
    .ram_exception (ram_exception)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];

  logic [7:0] mem     [0:8191];
  logic [7:0] ref_mem [0:8191];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit quiet = 1'b0;

  assign ram_exception = (ram_addr >= 32'h2000);
  assign ram_read = ram_exception ? 32'd0
                                  : {24'd0, mem[ram_addr[12:0]]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rw && !ram_exception)
      mem[ram_addr[12:0]] <= ram_write[7:0];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.resp_valid) begin
        if (rq.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = rq.pop_front();
          chk("rdata", ifc.resp_rdata, e.rdata);
          chk("fault", {31'd0, ifc.resp_fault}, {31'd0, e.fault});
          chk("resp_cycle", cyc, e.cyc);
        end
      end
      if (ram_rw) begin
        if (wq.size() == 0) begin
          chk("write_unexpected", ram_addr, 32'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", ram_addr, w.addr);
          chk("wr_data", ram_write, {24'd0, w.data});
          chk("wr_cycle", cyc, w.cyc);
          chk("ram_len", {30'd0, ram_len}, 32'd0);
        end
      end
      if (quiet) begin
        chk("quiet_rw", {31'd0, ram_rw}, 32'd0);
        chk("quiet_addr", ram_addr, 32'd0);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_ready", {31'd0, ifc.req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, ifc.resp_valid}, 32'd0);
    chk("rst_rdata", ifc.resp_rdata, 32'd0);
    chk("rst_fault", {31'd0, ifc.resp_fault}, 32'd0);
    chk("rst_rw", {31'd0, ram_rw}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_write", ram_write, 32'd0);
  endtask

  // cut < 0: full operation; cut >= 0: only cut bytes happen, no response.
  task automatic send(input logic        we,
                      input logic [1:0]  len,
                      input logic        uns,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input int          cut,
                      output int         t);
    int          n;
    int          nb;
    bit          bad;
    bit          exc;
    bit          ok;
    logic [31:0] v;
    rsp_t        r;
    @(negedge clk);
    ifc.req_valid    = 1'b1;
    ifc.req_we       = we;
    ifc.req_len      = len;
    ifc.req_unsigned = uns;
    ifc.req_addr     = addr;
    ifc.req_wdata    = wd;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ifc.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    t = cyc;
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    n   = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    bad = (len == 2'b11) || (len == 2'b01 && addr[0]) ||
          (len == 2'b10 && addr[1:0] != 2'b00);
    exc = !bad && (addr >= 32'h2000);
    nb  = (cut >= 0) ? cut : n;
    r.rdata = '0;
    r.fault = 1'b1;
    r.cyc   = t + 1;
    if (bad) begin
      r.cyc = t + 1;
    end else if (exc) begin
      r.cyc = t + 2;
      if (we) wq.push_back('{addr, wd[7:0], t + 1});
    end else begin
      r.fault = 1'b0;
      r.cyc   = t + 1 + n;
      v = '0;
      for (int b = 0; b < nb; b++) begin
        if (we) begin
          wq.push_back('{addr + b, wd[8*b +: 8], t + 1 + b});
          ref_mem[(addr[12:0] + 13'(b))] = wd[8*b +: 8];
        end else begin
          v[8*b +: 8] = ref_mem[(addr[12:0] + 13'(b))];
        end
      end
      if (!we && !uns) begin
        if (n == 1 && v[7])  v[31:8]  = '1;
        if (n == 2 && v[15]) v[31:16] = '1;
      end
      if (!we) r.rdata = v;
    end
    if (cut < 0) rq.push_back(r);
    @(posedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    ifc.req_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rq.size() == 0 && wq.size() == 0 && ifc.req_ready)
        break;
      @(negedge clk);
    end
    chk("drain_resp", rq.size(), 32'd0);
    chk("drain_writes", wq.size(), 32'd0);
  endtask

  initial begin
    int t;
    int tp;
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ifc.req_valid    = 1'b0;
    ifc.req_we       = 1'b0;
    ifc.req_len      = 2'b00;
    ifc.req_unsigned = 1'b0;
    ifc.req_addr     = '0;
    ifc.req_wdata    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    send(1'b1, 2'b10, 1'b0, 32'h100, 32'hA1B2C3D4, -1, t);
    drain();
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, -1, t);
    drain();

    send(1'b1, 2'b00, 1'b0, 32'h104, 32'h80, -1, t);
    send(1'b0, 2'b00, 1'b0, 32'h104, 32'h0, -1, t);
    send(1'b0, 2'b00, 1'b1, 32'h104, 32'h0, -1, t);
    send(1'b1, 2'b01, 1'b0, 32'h106, 32'h8001, -1, t);
    send(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, -1, t);
    send(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, -1, t);
    drain();

    quiet = 1'b1;
    send(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, -1, t);
    send(1'b1, 2'b10, 1'b0, 32'h102, 32'h55AA55AA, -1, t);
    send(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, -1, t);
    drain();
    quiet = 1'b0;

    send(1'b1, 2'b10, 1'b0, 32'h2000, 32'hDEADBEEF, -1, t);
    send(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, -1, t);
    send(1'b1, 2'b10, 1'b0, 32'h1FFC, 32'h01020304, -1, t);
    send(1'b0, 2'b10, 1'b1, 32'h1FFC, 32'h0, -1, t);
    send(1'b0, 2'b01, 1'b0, 32'h1FFE, 32'h0, -1, t);
    drain();

    send(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, -1, tp);
    for (int i = 1; i < 4; i++) begin
      send(1'b0, 2'b00, 1'b0, 32'h100 + i, 32'h0, -1, t);
      chk("b2b_spacing", t - tp, 32'd3);
      tp = t;
    end
    drain();

    send(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 2, t);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_no_resp", rq.size(), 32'd0);
    chk("rst_writes", wq.size(), 32'd0);

    send(1'b0, 2'b10, 1'b1, 32'h200, 32'h0, -1, t);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
